// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight at a time, with a per-transaction timeout watchdog.
module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_data_write,
    input  logic [31:0] mem_data_read,
    input  logic        mem_data_valid,
    output logic        err
);

    // Handshake: a requester raises req with stable address/data and holds it until
    // its one-cycle valid pulse; the arbiter completes a granted transaction even if
    // req drops meanwhile. Memory side: mem_* are held for the whole BUSY phase and
    // mem_data_valid is only honoured while BUSY.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [31:0]      ABORT_WORD = 32'hDEADBEEF;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] mem_addr_d;
    logic [3:0]  mem_we_d;
    logic [31:0] mem_wdata_d;
    logic [31:0] i_rdata_d;
    logic [31:0] d_rdata_d;
    logic        i_valid_d;
    logic        d_valid_d;
    logic        err_d;

    logic any_req;
    logic pick_data;
    logic timeout_hit;

    // Data wins only when fetch is absent or fetch was the previous owner.
    always_comb begin
        any_req     = i_req | d_req;
        pick_data   = d_req & (~i_req | (last_q == OWN_FETCH));
        timeout_hit = (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr;
        mem_we_d    = mem_we;
        mem_wdata_d = mem_data_write;
        i_rdata_d   = i_rdata;
        d_rdata_d   = d_rdata;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_we_d = 4'h0;
                if (any_req) begin
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                    if (pick_data) begin
                        owner_d     = OWN_DATA;
                        last_d      = OWN_DATA;
                        mem_addr_d  = d_addr;
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                    end else begin
                        owner_d     = OWN_FETCH;
                        last_d      = OWN_FETCH;
                        mem_addr_d  = i_addr;
                        mem_we_d    = 4'h0;
                        mem_wdata_d = 32'h0;
                    end
                end
            end

            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion takes priority over an abort landing in the same cycle.
                if (mem_data_valid) begin
                    mem_we_d = 4'h0;
                    state_d  = ST_RESP;
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d = mem_data_read;
                        d_valid_d = 1'b1;
                    end else begin
                        i_rdata_d = mem_data_read;
                        i_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    mem_we_d = 4'h0;
                    state_d  = ST_RESP;
                    err_d    = 1'b1;
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d = ABORT_WORD;
                        d_valid_d = 1'b1;
                    end else begin
                        i_rdata_d = ABORT_WORD;
                        i_valid_d = 1'b1;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                mem_we_d = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_FETCH;
            last_q         <= OWN_DATA;
            cnt_q          <= '0;
            mem_addr       <= 32'h0;
            mem_we         <= 4'h0;
            mem_data_write <= 32'h0;
            i_rdata        <= 32'h0;
            d_rdata        <= 32'h0;
            i_valid        <= 1'b0;
            d_valid        <= 1'b0;
            err            <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            mem_addr       <= mem_addr_d;
            mem_we         <= mem_we_d;
            mem_data_write <= mem_wdata_d;
            i_rdata        <= i_rdata_d;
            d_rdata        <= d_rdata_d;
            i_valid        <= i_valid_d;
            d_valid        <= d_valid_d;
            err            <= err_d;
        end
    end

endmodule
